// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard tracker: forwarding-select encoding
// and the default register-address width.
package hazard_pkg;

    localparam int REG_AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hazard_tracker_if.sv
// Decode-stage hazard inputs and stall/flush/forward controls between the
// pipeline and the hazard tracker.
interface hazard_tracker_if #(
    parameter int REG_AW = hazard_pkg::REG_AW_DEFAULT,
    parameter int CNT_W  = 16
);
    import hazard_pkg::*;

    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic              RegWriteD;
    logic              LoadD;
    logic              PCSrcE;
    logic              MemStallM;
    fwd_sel_t          ForwardAE;
    fwd_sel_t          ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic [CNT_W-1:0]  StallCount;

    // Pipeline side drives decode fields and control events; tracker answers.
    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE, MemStallM,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE, MemStallM,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount
    );

endinterface

// File: rtl/hazard_tracker_fwd_sel.sv
// One execute-operand forwarding select; the memory-stage producer is newer
// than the writeback-stage one, so it wins when both match.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int AW = REG_AW_DEFAULT
) (
    input  logic [AW-1:0] rs_e,
    input  logic [AW-1:0] rd_m,
    input  logic          reg_write_m,
    input  logic [AW-1:0] rd_w,
    input  logic          reg_write_w,
    output fwd_sel_t      sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
            sel = FWD_M;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Five-stage pipeline hazard unit: tracks E/M/W register usage, produces
// forwarding selects, load-use stalls, branch flushes and a stall counter.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_tracker_if.slave  hz
);

    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              we_e, ld_e, we_m, we_w;
    logic [CNT_W-1:0]  stall_cnt;
    fwd_sel_t          fwd_a, fwd_b;
    logic              load_use, flush_br, stall_lu, bubble_e;

    // Memory stall outranks a taken branch, which outranks a load-use stall.
    always_comb begin
        load_use = ld_e && we_e && (rd_e != '0) &&
                   ((rd_e == hz.Rs1D) || (rd_e == hz.Rs2D));
        flush_br = !hz.MemStallM && hz.PCSrcE;
        stall_lu = !hz.MemStallM && !hz.PCSrcE && load_use;
        bubble_e = flush_br || stall_lu;
    end

    fwd_sel #(.AW(REG_AW)) u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (we_m),
        .rd_w        (rd_w),
        .reg_write_w (we_w),
        .sel         (fwd_a)
    );

    fwd_sel #(.AW(REG_AW)) u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (we_m),
        .rd_w        (rd_w),
        .reg_write_w (we_w),
        .sel         (fwd_b)
    );

    assign hz.ForwardAE  = rst ? FWD_RF : fwd_a;
    assign hz.ForwardBE  = rst ? FWD_RF : fwd_b;
    assign hz.StallF     = !rst && (hz.MemStallM || stall_lu);
    assign hz.StallD     = !rst && (hz.MemStallM || stall_lu);
    assign hz.FlushD     = !rst && flush_br;
    assign hz.FlushE     = !rst && bubble_e;
    assign hz.StallCount = stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_e <= '0;
            rs2_e <= '0;
            rd_e  <= '0;
            we_e  <= 1'b0;
            ld_e  <= 1'b0;
            rd_m  <= '0;
            we_m  <= 1'b0;
            rd_w  <= '0;
            we_w  <= 1'b0;
        end else if (!hz.MemStallM) begin
            rd_w <= rd_m;
            we_w <= we_m;
            rd_m <= rd_e;
            we_m <= we_e;
            if (bubble_e) begin
                rs1_e <= '0;
                rs2_e <= '0;
                rd_e  <= '0;
                we_e  <= 1'b0;
                ld_e  <= 1'b0;
            end else begin
                rs1_e <= hz.Rs1D;
                rs2_e <= hz.Rs2D;
                rd_e  <= hz.RdD;
                we_e  <= hz.RegWriteD;
                ld_e  <= hz.LoadD;
            end
        end
    end

    // Saturating count of load-use bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_lu && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: an instruction-level pipeline model is
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_hazard_tracker;

    localparam int AW    = 5;
    localparam int CW    = 3;
    localparam int C_MAX = (1 << CW) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   passed;

    hazard_tracker_if #(.REG_AW(AW), .CNT_W(CW)) hz ();

    hazard_tracker #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction-level model ----------------
    typedef struct packed {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          we;
        logic          ld;
    } ins_t;

    ins_t m_e, m_m, m_w;
    int   m_cnt;

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
        if (m_m.we && m_m.rd != 0 && m_m.rd == rs) return 2'b10;
        if (m_w.we && m_w.rd != 0 && m_w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_load_use();
        return m_e.ld && m_e.we && m_e.rd != 0 &&
               (m_e.rd == hz.Rs1D || m_e.rd == hz.Rs2D);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_e   <= '0;
            m_m   <= '0;
            m_w   <= '0;
            m_cnt <= 0;
        end else if (!hz.MemStallM) begin
            if (!hz.PCSrcE && exp_load_use() && m_cnt < C_MAX) m_cnt <= m_cnt + 1;
            m_w <= m_m;
            m_m <= m_e;
            if (hz.PCSrcE || exp_load_use()) m_e <= '0;
            else m_e <= {hz.Rs1D, hz.Rs2D, hz.RdD, hz.RegWriteD, hz.LoadD};
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic br, lu;
        if (rst) begin
            check("m_rst_fwda", 32'(hz.ForwardAE), 0);
            check("m_rst_fwdb", 32'(hz.ForwardBE), 0);
            check("m_rst_stallf", 32'(hz.StallF), 0);
            check("m_rst_stalld", 32'(hz.StallD), 0);
            check("m_rst_flushd", 32'(hz.FlushD), 0);
            check("m_rst_flushe", 32'(hz.FlushE), 0);
            check("m_rst_cnt", 32'(hz.StallCount), 0);
        end else begin
            br = !hz.MemStallM && hz.PCSrcE;
            lu = !hz.MemStallM && !hz.PCSrcE && exp_load_use();
            check("m_fwda", 32'(hz.ForwardAE), 32'(exp_fwd(m_e.rs1)));
            check("m_fwdb", 32'(hz.ForwardBE), 32'(exp_fwd(m_e.rs2)));
            check("m_stallf", 32'(hz.StallF), 32'(hz.MemStallM || lu));
            check("m_stalld", 32'(hz.StallD), 32'(hz.MemStallM || lu));
            check("m_flushd", 32'(hz.FlushD), 32'(br));
            check("m_flushe", 32'(hz.FlushE), 32'(br || lu));
            check("m_cnt", 32'(hz.StallCount), 32'(m_cnt));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we, input logic ld);
        hz.Rs1D      = rs1;
        hz.Rs2D      = rs2;
        hz.RdD       = rd;
        hz.RegWriteD = we;
        hz.LoadD     = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b1;
        hz.PCSrcE = 1'b1;
        hz.MemStallM = 1'b1;
        drive(3, 4, 5, 1, 1);
        #2;
        check("rst_stallf", 32'(hz.StallF), 0);
        check("rst_flushd", 32'(hz.FlushD), 0);
        check("rst_fwda", 32'(hz.ForwardAE), 0);
        check("rst_cnt", 32'(hz.StallCount), 0);
        tick();
        tick();
        rst = 1'b0;
        hz.PCSrcE = 1'b0;
        hz.MemStallM = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();

        // add x5 ; add x6,x5,x1
        drive(1, 2, 5, 1, 0); tick();
        drive(5, 1, 6, 1, 0); tick();
        drive(0, 0, 0, 0, 0); #1;
        check("alu_fwda", 32'(hz.ForwardAE), 2);
        check("alu_fwdb", 32'(hz.ForwardBE), 0);
        tick();

        // x7 written in both M and W
        drive(0, 0, 7, 1, 0); tick();
        drive(0, 0, 7, 1, 0); tick();
        drive(0, 7, 10, 1, 0); tick();
        drive(0, 0, 0, 0, 0); #1;
        check("m_over_w", 32'(hz.ForwardBE), 2);
        tick();
        drive(0, 0, 7, 1, 0); tick();
        drive(0, 0, 7, 0, 0); tick();
        drive(0, 7, 10, 1, 0); tick();
        drive(0, 0, 0, 0, 0); #1;
        check("w_only", 32'(hz.ForwardBE), 1);
        tick();

        // lw x8 ; add x9,x8,x8
        drive(1, 0, 8, 1, 1); tick();
        drive(8, 8, 9, 1, 0); #1;
        check("lu_stallf", 32'(hz.StallF), 1);
        check("lu_stalld", 32'(hz.StallD), 1);
        check("lu_flushe", 32'(hz.FlushE), 1);
        check("lu_flushd", 32'(hz.FlushD), 0);
        check("lu_cnt0", 32'(hz.StallCount), 0);
        tick();
        check("lu_cnt1", 32'(hz.StallCount), 1);
        check("lu_released", 32'(hz.StallF), 0);
        tick();
        drive(0, 0, 0, 0, 0); #1;
        check("lu_fwda", 32'(hz.ForwardAE), 1);
        check("lu_fwdb", 32'(hz.ForwardBE), 1);
        tick();

        // branch taken while decode has a load-use match
        drive(1, 0, 11, 1, 1); tick();
        drive(11, 0, 12, 1, 0);
        hz.PCSrcE = 1'b1; #1;
        check("br_flushd", 32'(hz.FlushD), 1);
        check("br_flushe", 32'(hz.FlushE), 1);
        check("br_stallf", 32'(hz.StallF), 0);
        check("br_stalld", 32'(hz.StallD), 0);
        tick();
        hz.PCSrcE = 1'b0;
        drive(0, 0, 0, 0, 0); #1;
        check("br_cnt", 32'(hz.StallCount), 1);
        tick();

        // memory stall freezes the pipeline for three cycles
        drive(0, 0, 13, 1, 0); tick();
        drive(13, 0, 14, 1, 0); tick();
        drive(0, 0, 0, 0, 0);
        hz.MemStallM = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hz.PCSrcE = (k == 1);
            #1;
            check("ms_fwda", 32'(hz.ForwardAE), 2);
            check("ms_stallf", 32'(hz.StallF), 1);
            check("ms_stalld", 32'(hz.StallD), 1);
            check("ms_flushd", 32'(hz.FlushD), 0);
            check("ms_flushe", 32'(hz.FlushE), 0);
            tick();
        end
        hz.MemStallM = 1'b0;
        hz.PCSrcE = 1'b0; #1;
        check("ms_release_fwda", 32'(hz.ForwardAE), 2);
        tick();
        check("ms_advanced_fwda", 32'(hz.ForwardAE), 0);

        // reset during a load-use stall, then x0 traffic
        drive(1, 0, 15, 1, 1); tick();
        drive(15, 0, 16, 1, 0); #1;
        check("pre_rst_stall", 32'(hz.StallF), 1);
        rst = 1'b1; #1;
        check("mid_rst_stallf", 32'(hz.StallF), 0);
        check("mid_rst_flushe", 32'(hz.FlushE), 0);
        check("mid_rst_cnt", 32'(hz.StallCount), 0);
        tick();
        rst = 1'b0; #1;
        check("post_rst_stallf", 32'(hz.StallF), 0);
        tick();
        drive(1, 0, 0, 1, 1); tick();
        drive(0, 0, 0, 1, 0); #1;
        check("x0_stallf", 32'(hz.StallF), 0);
        check("x0_flushe", 32'(hz.FlushE), 0);
        tick();
        drive(0, 0, 0, 0, 0); #1;
        check("x0_fwda", 32'(hz.ForwardAE), 0);
        tick();

        // nine load-use stalls saturate the 3-bit counter at 7
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 20, 1, 1); tick();
            drive(20, 0, 21, 1, 0); tick();
            tick();
        end
        drive(0, 0, 0, 0, 0); #1;
        check("cnt_sat", 32'(hz.StallCount), 7);
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 Parameter REG_AW, default 5, SHALL set the register-address width.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the stall-statistics counter.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Rs1D, Rs2D  in  REG_AW  SHALL be the decode-stage source register addresses.
REQ-006 RdD  in  REG_AW  SHALL be the decode-stage destination address.
REQ-007 RegWriteD  in  1  SHALL mark that the decode instruction writes RdD.
REQ-008 LoadD  in  1  SHALL mark that the decode instruction is a load.
REQ-009 PCSrcE  in  1  SHALL flag a taken branch or jump resolved in execute.
REQ-010 MemStallM  in  1  SHALL flag that data memory is busy and the whole pipeline freezes.
REQ-011 ForwardAE, ForwardBE  out  2  SHALL be the execute-operand forwarding selects.
REQ-012 StallF, StallD  out  1  SHALL be the fetch and decode hold enables.
REQ-013 FlushD, FlushE  out  1  SHALL be the decode and execute bubble-insert controls.
REQ-014 StallCount  out  CNT_W  SHALL count load-use stall cycles.

Function
REQ-015 Internal E-stage state SHALL be Rs1E, Rs2E, RdE, RegWriteE and LoadE; M-stage state SHALL be RdM and RegWriteM; W-stage state SHALL be RdW and RegWriteW.
REQ-016 Normal advance SHALL copy D fields to E, E to M and M to W on every edge.
REQ-017 When MemStallM=1, all internal stage state SHALL hold; StallF=StallD=1 and FlushD=FlushE=0.
REQ-018 When MemStallM=0 and PCSrcE=1, FlushD=FlushE=1, StallF=StallD=0, and the E state SHALL load as a bubble: all fields 0, with M<-E and W<-M.
REQ-019 A load-use hazard SHALL be LoadE & RegWriteE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-020 On a load-use hazard with MemStallM=0 and PCSrcE=0, StallF=StallD=FlushE=1, FlushD=0; E SHALL load as a bubble and M/W SHALL advance.
REQ-021 Priority SHALL be MemStallM > PCSrcE > load-use.
REQ-022 Forward select encoding SHALL be 00 = register file, 01 = ResultW, 10 = ALUResultM; 11 SHALL never be driven.
REQ-023 ForwardAE SHALL be 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00.
REQ-024 ForwardBE SHALL be computed as in REQ-023 using Rs2E.
REQ-025 The M-stage match SHALL take priority over the W-stage match when both match.
REQ-026 Forward selects and stall/flush outputs SHALL be combinational from current state and inputs, with zero-cycle latency.
REQ-027 StallCount SHALL increment on each edge where REQ-020 applies and SHALL saturate at all-ones without wrapping.
REQ-028 Register x0 SHALL never cause a forward or a stall.

Reset
REQ-029 While rst=1, all internal state and StallCount SHALL be 0 asynchronously.
REQ-030 While rst=1, every output SHALL be 0 regardless of the other inputs.
REQ-031 Reset asserted mid-stall or mid-flush SHALL discard the pending bubble; the first edge after release SHALL perform a normal advance.

Structure
REQ-032 Package hazard_pkg SHALL hold the fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10) and the default REG_AW.
REQ-033 Sub-module fwd_sel SHALL compute one forward select from (RsE, RdM, RegWriteM, RdW, RegWriteW) and SHALL be instantiated twice.

Verification
REQ-034 add x5 then add x6,x5,x1 -> cycle 2: ForwardAE=10, ForwardBE=00.
REQ-035 Write x7 in M and in W at the same time, Rs2E=7 -> ForwardBE=10; with RegWriteM=0 -> ForwardBE=01.
REQ-036 lw x8 then add x9,x8,x8 -> one cycle of StallF=StallD=FlushE=1, StallCount 0->1; next cycle ForwardAE=ForwardBE=01.
REQ-037 PCSrcE=1 together with a load-use match in D -> FlushD=FlushE=1, StallF=StallD=0, StallCount unchanged.
REQ-038 MemStallM=1 for 3 cycles mid-sequence -> state frozen, forward selects constant, flushes 0; normal advance resumes after release.
REQ-039 rst pulse during a load-use stall, plus writes to x0 -> all outputs 0 during reset; no forward or stall for Rd=0.
